arm_mul_unit: RTL and testbench

ARM_MUL_UNIT -- requirements
Module: arm_mul_unit

---
 rtl/arm_mul_unit.sv | 118 +++++++++++
 tb/tb_arm_mul_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mul_unit.sv
// Iterative shift-add multiplier for MUL/MLA/UMULL/SMULL: one multiplier bit per cycle.
// SMULL multiplies operand magnitudes and negates the 2*WIDTH product on completion.
module arm_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       MulOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] SrcAcc,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MLA   = 2'b01,
        OP_UMULL = 2'b10,
        OP_SMULL = 2'b11
    } op_t;

    state_t             state, state_nxt;
    op_t                op;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, mcand, prod, prod_fix;
    logic [WIDTH-1:0]   mplier, acc_op, mag_a, mag_b, res_lo, res_hi;
    logic               neg, smull_in, accept, last;

    assign accept   = (state == IDLE) && start;
    assign last     = (state == RUN) && (cnt == LAST);
    assign smull_in = (MulOp == 2'b11);

    always_comb begin
        mag_a = (smull_in && SrcA[WIDTH-1]) ? -SrcA : SrcA;
        mag_b = (smull_in && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Final value is formed from the accumulator plus the last partial product,
    // so results land on the same edge that enters DONE.
    always_comb begin
        prod     = acc + (mplier[0] ? mcand : '0);
        prod_fix = neg ? -prod : prod;
        res_lo   = prod_fix[WIDTH-1:0];
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        case (op)
            OP_MUL: res_hi = '0;
            OP_MLA: begin
                res_lo = prod[WIDTH-1:0] + acc_op;
                res_hi = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op       <= OP_MUL;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc_op   <= '0;
            neg      <= 1'b0;
            ResultLo <= '0;
            ResultHi <= '0;
            MulFlags <= '0;
        end else if (accept) begin
            op     <= op_t'(MulOp);
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc_op <= SrcAcc;
            neg    <= smull_in & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
        end else if (state == RUN) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                ResultLo <= res_lo;
                ResultHi <= res_hi;
                MulFlags <= {op[1] ? res_hi[WIDTH-1] : res_lo[WIDTH-1],
                             ({res_hi, res_lo} == '0)};
            end
        end
    end

endmodule

// File: tb/tb_arm_mul_unit.sv
// Scoreboard bench for arm_mul_unit at WIDTH=32 and WIDTH=8: stimulus pushes expected
// results with their due cycle; monitors pop and compare on every done pulse.
module tb_arm_mul_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        s32, s8;
    logic [1:0]  op32, op8;
    logic [31:0] a32, b32, c32, lo32, hi32;
    logic [7:0]  a8, b8, c8, lo8, hi8;
    logic [1:0]  f32, f8;
    logic        busy32, done32, busy8, done8;

    arm_mul_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(s32), .MulOp(op32),
        .SrcA(a32), .SrcB(b32), .SrcAcc(c32),
        .ResultLo(lo32), .ResultHi(hi32), .MulFlags(f32),
        .busy(busy32), .done(done32)
    );

    arm_mul_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(s8), .MulOp(op8),
        .SrcA(a8), .SrcB(b8), .SrcAcc(c8),
        .ResultLo(lo8), .ResultHi(hi8), .MulFlags(f8),
        .busy(busy8), .done(done8)
    );

    typedef struct {
        logic [63:0] lo;
        logic [63:0] hi;
        logic [1:0]  f;
        int unsigned at;
        string       name;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    exp_t        e32, e8;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut32 unexpected done at cycle %0d: got 1 expected 0", cyc);
            end else begin
                e32 = q32.pop_front();
                chk({e32.name, " lo"},    {32'h0, lo32}, e32.lo);
                chk({e32.name, " hi"},    {32'h0, hi32}, e32.hi);
                chk({e32.name, " flags"}, {62'h0, f32},  {62'h0, e32.f});
                chk({e32.name, " cycle"}, 64'(cyc),      64'(e32.at));
            end
        end
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut8 unexpected done at cycle %0d: got 1 expected 0", cyc);
            end else begin
                e8 = q8.pop_front();
                chk({e8.name, " lo"},    {56'h0, lo8}, e8.lo);
                chk({e8.name, " hi"},    {56'h0, hi8}, e8.hi);
                chk({e8.name, " flags"}, {62'h0, f8},  {62'h0, e8.f});
                chk({e8.name, " cycle"}, 64'(cyc),     64'(e8.at));
            end
        end
    end

    task automatic wait_idle32();
        int unsigned n = 0;
        @(negedge clk);
        while (busy32 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL dut32 idle timeout: got busy 1 expected 0");
        end
    endtask

    task automatic wait_idle8();
        int unsigned n = 0;
        @(negedge clk);
        while (busy8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL dut8 idle timeout: got busy 1 expected 0");
        end
    endtask

    task automatic go32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] elo, input logic [31:0] ehi,
                        input logic [1:0] ef, input string nm);
        exp_t e;
        wait_idle32();
        op32 = op; a32 = a; b32 = b; c32 = c; s32 = 1'b1;
        @(posedge clk);
        #1;
        e.lo = {32'h0, elo}; e.hi = {32'h0, ehi}; e.f = ef; e.at = cyc + 32; e.name = nm;
        q32.push_back(e);
        s32 = 1'b0;
    endtask

    task automatic go8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] elo, input logic [7:0] ehi,
                       input logic [1:0] ef, input string nm);
        exp_t e;
        wait_idle8();
        op8 = op; a8 = a; b8 = b; c8 = c; s8 = 1'b1;
        @(posedge clk);
        #1;
        e.lo = {56'h0, elo}; e.hi = {56'h0, ehi}; e.f = ef; e.at = cyc + 8; e.name = nm;
        q8.push_back(e);
        s8 = 1'b0;
    endtask

    initial begin
        exp_t        e;
        int unsigned n0;
        int unsigned n;
        reset = 1'b1;
        s32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0; c32 = '0;
        s8  = 1'b0; op8  = 2'b00; a8  = '0; b8  = '0; c8  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset lo",    {32'h0, lo32},  64'h0);
        chk("reset hi",    {32'h0, hi32},  64'h0);
        chk("reset flags", {62'h0, f32},   64'h0);
        chk("reset busy",  {63'h0, busy32}, 64'h0);
        chk("reset done",  {63'h0, done32}, 64'h0);

        go32(2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 32'd0, 2'b00, "mul7x6");
        go32(2'b01, 32'd3, 32'd4, 32'hFFFFFFF4, 32'd0, 32'd0, 2'b01, "mla_wrap");
        go32(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h00000001, 32'hFFFFFFFE, 2'b10, "umull_max");
        go32(2'b11, 32'hFFFFFFFD, 32'd5, 32'd0, 32'hFFFFFFF1, 32'hFFFFFFFF, 2'b10, "smull_m3x5");
        go32(2'b11, 32'h80000000, 32'h80000000, 32'd0, 32'h0, 32'h40000000, 2'b00, "smull_minmin");
        go32(2'b00, 32'h00010000, 32'h00010000, 32'd0, 32'h0, 32'h0, 2'b01, "mul_ovf");
        go32(2'b00, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 32'h0, 2'b10, "mul_neg");
        go32(2'b11, 32'd7, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 2'b10, "smull_7xm1");
        go32(2'b11, 32'd0, 32'hFFFFFFFF, 32'd0, 32'h0, 32'h0, 2'b01, "smull_zero");
        go32(2'b01, 32'h10, 32'h10, 32'd5, 32'h105, 32'h0, 2'b00, "mla_small");
        go32(2'b10, 32'h80000000, 32'd2, 32'd0, 32'h0, 32'h1, 2'b00, "umull_carry");

        // start re-pulsed mid-run with new operands must be ignored
        go32(2'b00, 32'd9, 32'd9, 32'd0, 32'd81, 32'd0, 2'b00, "mul_repulse");
        repeat (5) @(negedge clk);
        a32 = 32'd100; b32 = 32'd100; op32 = 2'b10; s32 = 1'b1;
        repeat (2) @(negedge clk);
        s32 = 1'b0;

        // reset ten cycles into a run aborts it and clears the prior result
        wait_idle32();
        op32 = 2'b00; a32 = 32'd5; b32 = 32'd5; s32 = 1'b1;
        @(posedge clk);
        #1;
        s32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort lo",    {32'h0, lo32},   64'h0);
        chk("abort hi",    {32'h0, hi32},   64'h0);
        chk("abort flags", {62'h0, f32},    64'h0);
        chk("abort busy",  {63'h0, busy32}, 64'h0);
        chk("abort done",  {63'h0, done32}, 64'h0);
        go32(2'b00, 32'd2, 32'd2, 32'd0, 32'd4, 32'd0, 2'b00, "mul_after_abort");

        // start held high: second op accepted after DONE plus one IDLE cycle
        wait_idle32();
        op32 = 2'b10; a32 = 32'd3; b32 = 32'd5; c32 = 32'd0; s32 = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        e.lo = 64'd15; e.hi = 64'd0; e.f = 2'b00; e.at = n0 + 32; e.name = "b2b_first";
        q32.push_back(e);
        e.at = n0 + 66; e.name = "b2b_second";
        q32.push_back(e);
        repeat (34) @(posedge clk);
        #1;
        s32 = 1'b0;

        go8(2'b10, 8'hFF, 8'h02, 8'h00, 8'hFE, 8'h01, 2'b00, "w8_umull");
        go8(2'b11, 8'h80, 8'h80, 8'h00, 8'h00, 8'h40, 2'b00, "w8_smull_minmin");
        go8(2'b00, 8'h0F, 8'h11, 8'h00, 8'hFF, 8'h00, 2'b10, "w8_mul");
        go8(2'b01, 8'h10, 8'h10, 8'h01, 8'h01, 8'h00, 2'b00, "w8_mla_wrap");

        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("pending done count", 64'(q32.size() + q8.size()), 64'h0);
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
